// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: M-stage load/store sequencer with alignment checks, store lane build and load extract.
// Latency: 3 cycles per aligned access (IDLE accept, BUSY, DONE) plus one cycle per extra BUSY cycle waiting for bus_ack.
// Backpressure: m_stall holds the pipeline from accept until DONE; misaligned accesses fault the same cycle without stalling.
// Optional: define DM_BUS_TIMEOUT_EN to abort BUSY with a bus error (code 7) after TIMEOUT cycles without bus_ack.

module dm_access_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic [2:0]  m_slctrl,
  output logic        m_stall,
  output logic [31:0] m_rdata,
  output logic        m_exc,
  output logic [4:0]  m_exccode,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("dm_access_ctrl: TIMEOUT must be in 1..255");
  end

  state_t      state;
  logic [2:0]  slctrl_q;   // size/sign of the access in flight
  logic [1:0]  lane_q;     // byte offset of the access in flight

  logic        misaligned;
  logic [31:0] wdata_lane;
  logic [3:0]  be_lane;
  logic [31:0] load_ext;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

`ifdef DM_BUS_TIMEOUT_EN
  localparam logic [4:0] EXC_DBE = 5'd7;
  logic [7:0]  busy_cnt;
  logic        tmo_err;    // DONE reached through expiry rather than ack
`endif

  // Alignment check and store lane replication on the live M-stage inputs
  always_comb begin
    misaligned = 1'b0;
    wdata_lane = m_wdata;
    be_lane    = 4'b1111;
    case (m_slctrl[1:0])
      SZ_WORD: misaligned = (m_addr[1:0] != 2'b00);
      SZ_HALF: begin
        misaligned = m_addr[0];
        wdata_lane = {2{m_wdata[15:0]}};
        be_lane    = m_addr[1] ? 4'b1100 : 4'b0011;
      end
      SZ_BYTE: begin
        wdata_lane = {4{m_wdata[7:0]}};
        be_lane    = 4'b0001 << m_addr[1:0];
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Pick the addressed lane out of the returned word and extend it
  always_comb begin
    rd_byte  = bus_rdata[{lane_q, 3'b000} +: 8];
    rd_half  = bus_rdata[{lane_q[1], 4'b0000} +: 16];
    load_ext = bus_rdata;
    case (slctrl_q[1:0])
      SZ_HALF: load_ext = {{16{slctrl_q[2] & rd_half[15]}}, rd_half};
      SZ_BYTE: load_ext = {{24{slctrl_q[2] & rd_byte[7]}}, rd_byte};
      default: load_ext = bus_rdata;
    endcase
  end

  // Pipeline-facing stall and exception, combinational from state and M inputs
  always_comb begin
    m_stall   = 1'b0;
    m_exc     = 1'b0;
    m_exccode = 5'd0;
    case (state)
      IDLE: begin
        if (m_req) begin
          if (misaligned) begin
            m_exc     = 1'b1;
            m_exccode = m_we ? EXC_ADES : EXC_ADEL;
          end else begin
            m_stall = 1'b1;
          end
        end
      end
      BUSY: m_stall = 1'b1;
      DONE: begin
`ifdef DM_BUS_TIMEOUT_EN
        if (tmo_err) begin
          m_exc     = 1'b1;
          m_exccode = EXC_DBE;
        end
`endif
      end
      default: m_stall = 1'b0;
    endcase
  end

  // Access sequencer: registered bus side and load result
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
      m_rdata   <= 32'd0;
      slctrl_q  <= 3'd0;
      lane_q    <= 2'd0;
`ifdef DM_BUS_TIMEOUT_EN
      busy_cnt  <= 8'd0;
      tmo_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (m_req && !misaligned) begin
            bus_req   <= 1'b1;
            bus_we    <= m_we;
            bus_addr  <= {m_addr[31:2], 2'b00};
            bus_be    <= m_we ? be_lane : 4'b0000;
            bus_wdata <= wdata_lane;
            slctrl_q  <= m_slctrl;
            lane_q    <= m_addr[1:0];
            state     <= BUSY;
`ifdef DM_BUS_TIMEOUT_EN
            busy_cnt  <= 8'd0;
            tmo_err   <= 1'b0;
`endif
          end
        end
        BUSY: begin
          // An ack in the expiry cycle takes priority over the timeout
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) m_rdata <= load_ext;
            state   <= DONE;
          end
`ifdef DM_BUS_TIMEOUT_EN
          else if (busy_cnt + 8'd1 == 8'(TIMEOUT)) begin
            bus_req  <= 1'b0;
            m_rdata  <= 32'd0;
            tmo_err  <= 1'b1;
            busy_cnt <= busy_cnt + 8'd1;
            state    <= DONE;
          end else begin
            busy_cnt <= busy_cnt + 8'd1;
          end
`endif
        end
        DONE: begin
          // m_req here still belongs to the finished instruction
          state <= IDLE;
`ifdef DM_BUS_TIMEOUT_EN
          tmo_err <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
module tb_dm_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [2:0]  m_slctrl;
  logic        m_stall;
  logic [31:0] m_rdata;
  logic        m_exc;
  logic [4:0]  m_exccode;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  dm_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_slctrl  (m_slctrl),
    .m_stall   (m_stall),
    .m_rdata   (m_rdata),
    .m_exc     (m_exc),
    .m_exccode (m_exccode),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference rules written from the access semantics with plain arithmetic
  function automatic bit f_mis(input logic [2:0] sl, input logic [31:0] a);
    int sz = int'(sl[1:0]);
    if (sz == 3) return 1;
    if (sz == 0) return (a % 4) != 0;
    if (sz == 1) return (a % 2) != 0;
    return 0;
  endfunction

  function automatic logic [3:0] f_be(input logic [2:0] sl, input logic [31:0] a);
    int off = int'(a % 4);
    if (sl[1:0] == 2'd2) return 4'(1 << off);
    if (sl[1:0] == 2'd1) return (off >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [2:0] sl, input logic [31:0] w);
    if (sl[1:0] == 2'd2) return (w & 32'hFF) * 32'h0101_0101;
    if (sl[1:0] == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] f_rdata(input logic [2:0] sl, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    int off = int'(a % 4);
    if (sl[1:0] == 2'd2) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (sl[2] && v >= 32'h80) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (sl[1:0] == 2'd1) begin
      v = (rd >> (16 * (off / 2))) & 32'hFFFF;
      if (sl[2] && v >= 32'h8000) v = v + 32'hFFFF_0000;
      return v;
    end
    return rd;
  endfunction

  // One M-stage access, acked after 'delay' extra BUSY cycles, checked every cycle
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [2:0] sl, input int delay, input logic [31:0] rd);
    bit mis;
    bit tmo;
    int nbusy;
    mis = f_mis(sl, addr);
    m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wd; m_slctrl = sl; bus_ack = 1'b0;
    @(negedge clk);
    chk("acc_stall", m_stall, !mis);
    chk("acc_exc", m_exc, mis);
    chk("acc_code", m_exccode, mis ? (we ? 5 : 4) : 0);
    if (mis) begin
      @(posedge clk); #1;
      m_req = 1'b0;
      @(negedge clk);
      chk("mis_noreq", bus_req, 0);
      chk("mis_stall", m_stall, 0);
      return;
    end
    tmo = 0;
    nbusy = delay + 1;
`ifdef DM_BUS_TIMEOUT_EN
    if (delay >= TO) begin
      tmo = 1;
      nbusy = TO;
    end
`endif
    @(posedge clk); #1;
    for (int k = 0; k < nbusy; k++) begin
      bus_ack   = (k == delay);
      bus_rdata = (k == delay) ? rd : $urandom;
      m_addr    = $urandom;
      m_wdata   = $urandom;
      @(negedge clk);
      chk("busy_req", bus_req, 1);
      chk("busy_stall", m_stall, 1);
      chk("busy_exc", m_exc, 0);
      chk("busy_addr", bus_addr, addr & 32'hFFFF_FFFC);
      chk("busy_we", bus_we, we);
      chk("busy_be", bus_be, we ? f_be(sl, addr) : 4'd0);
      if (we) chk("busy_wdata", bus_wdata, f_wdata(sl, wd));
      @(posedge clk); #1;
    end
    bus_ack   = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    @(negedge clk);
    chk("done_stall", m_stall, 0);
    chk("done_req", bus_req, 0);
    chk("done_exc", m_exc, tmo);
    chk("done_code", m_exccode, tmo ? 7 : 0);
    if (tmo) chk("done_rdata_tmo", m_rdata, 0);
    else if (!we) chk("done_rdata", m_rdata, f_rdata(sl, addr, rd));
    @(posedge clk); #1;
    m_req = 1'b0;
    bus_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("idle_stall", m_stall, 0);
    chk("idle_req", bus_req, 0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [2:0] sl;
    reset = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0; m_slctrl = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req", bus_req, 0);
    chk("rst_we", bus_we, 0);
    chk("rst_be", bus_be, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_rdata", m_rdata, 0);
    chk("rst_stall", m_stall, 0);
    chk("rst_exc", m_exc, 0);
    chk("rst_code", m_exccode, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_access(1'b1, 32'h0000_0013, 32'h1234_56AB, 3'b010, 0, 32'h0);
    run_access(1'b0, 32'h0000_0006, 32'h0, 3'b101, 3, 32'h8001_7FFF);
    run_access(1'b0, 32'h0000_0002, 32'h0, 3'b000, 0, 32'h0);
    run_access(1'b1, 32'h0000_0001, 32'h0, 3'b001, 0, 32'h0);
    run_access(1'b0, 32'h0000_0003, 32'h0, 3'b110, 1, 32'h80FF_7F00);

    // Reset in the second BUSY cycle of a store, then a late ack
    m_req = 1'b1; m_we = 1'b1; m_addr = 32'h0000_0100; m_wdata = 32'hDEAD_BEEF; m_slctrl = 3'b000;
    @(negedge clk);
    chk("rb_accept_stall", m_stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rb_busy1_req", bus_req, 1);
    @(posedge clk); #1;
    reset = 1'b1; m_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rb_req", bus_req, 0);
    chk("rb_stall", m_stall, 0);
    chk("rb_be", bus_be, 0);
    chk("rb_addr", bus_addr, 0);
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
    @(negedge clk);
    chk("rb_late_stall", m_stall, 0);
    chk("rb_late_exc", m_exc, 0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("rb_after_req", bus_req, 0);
    chk("rb_after_stall", m_stall, 0);
    chk("rb_after_rdata", m_rdata, 0);
    @(posedge clk); #1;

`ifdef DM_BUS_TIMEOUT_EN
    run_access(1'b0, 32'h0000_0044, 32'h0, 3'b000, 10, 32'hCAFE_F00D);
    run_access(1'b1, 32'h0000_0048, 32'h5555_AAAA, 3'b000, TO, 32'h0);
    run_access(1'b0, 32'h0000_004C, 32'h0, 3'b000, TO - 1, 32'h1357_9BDF);
`else
    run_access(1'b0, 32'h0000_0040, 32'h0, 3'b000, 300, 32'hCAFE_F00D);
`endif

    // Randomized accesses
    for (int i = 0; i < 150; i++) begin
      sl = 3'($urandom_range(0, 7));
`ifdef DM_BUS_TIMEOUT_EN
      run_access(1'($urandom_range(0, 1)), $urandom, $urandom, sl, $urandom_range(0, 6), $urandom);
`else
      run_access(1'($urandom_range(0, 1)), $urandom, $urandom, sl, $urandom_range(0, 4), $urandom);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_access_ctrl.md
# dm_access_ctrl

Sequencer between the M stage and the system bridge for all data-memory and peripheral accesses. Accepts one load/store per instruction and checks alignment. For stores it builds lane-replicated write data and byte enables; for loads it extracts and extends the returned lane. It runs a req/ack handshake with the bridge and stalls the pipeline until the access completes. It also raises AdEL/AdES, or a bus error if the optional timeout is enabled, towards CP0.

## Interface
- `TIMEOUT`, 15: max BUSY cycles without `bus_ack` before bus error. Only used when the timeout is compiled in. Legal range 1..255.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `m_req` in 1: M-stage instruction is a load or store.
- `m_we` in 1: 1 = store, 0 = load.
- `m_addr` in 32: byte address.
- `m_wdata` in 32: raw rt value. Low byte or halfword is used for sb/sh.
- `m_slctrl` in 3: `[1:0]` size: 00 word, 01 half, 10 byte, 11 reserved. `[2]` sign-extend for loads; ignored for stores.
- `m_stall` out 1: freeze F/D/E/M.
- `m_rdata` out 32: extended load result, valid in DONE.
- `m_exc` out 1: exception for the current M instruction.
- `m_exccode` out 5: 4 AdEL, 5 AdES, 7 DBE. 0 when `m_exc`=0.
- `bus_req` out 1: request to bridge, registered.
- `bus_we` out 1: registered.
- `bus_addr` out 32: `{addr[31:2],2'b00}`, registered.
- `bus_be` out 4: byte enables, registered. 0000 for loads.
- `bus_wdata` out 32: lane-replicated store data, registered.
- `bus_ack` in 1: bridge completion, one-cycle pulse.
- `bus_rdata` in 32: word read data, valid with `bus_ack`.

## Operation
- **States:** IDLE, BUSY, DONE.
- **Misalignment** (combinational, evaluated in IDLE):
  - word with `addr[1:0]`≠0;
  - half with `addr[0]`≠0;
  - size 11.
- **IDLE, `m_req`=1, misaligned:**
  - `m_exc`=1; `m_exccode`=5 if `m_we`, else 4.
  - `m_stall`=0. No bus activity. Stay in IDLE.
- **IDLE, `m_req`=1, aligned:**
  - `m_stall`=1.
  - Latch addr, we, slctrl, and lane-built wdata/be into bus registers.
  - Go to BUSY.
- **Store lanes:**
  - byte: wdata `{4{b}}`, be `0001<<addr[1:0]`;
  - half: wdata `{2{h}}`, be `addr[1]?1100:0011`;
  - word: data as-is, be 1111.
- **BUSY:**
  - `bus_req`=1, `m_stall`=1; bus outputs held stable.
  - On `bus_ack`: capture the extracted and extended `bus_rdata` into the rdata register (loads only), clear `bus_req`, go to DONE.
- **Load extract:**
  - byte: lane `addr[1:0]`;
  - half: lane `addr[1]`;
  - zero- or sign-extend per `slctrl[2]`. Word is unchanged.
- **DONE:**
  - `m_stall`=0, `m_rdata` valid, `bus_req`=0.
  - The pipeline advances at the end of this cycle. `m_req` seen in DONE belongs to the finished instruction and is ignored.
  - Always return to IDLE.
- **Stray `bus_ack`** in IDLE or DONE: ignored.
- **Reset:**
  - Any state goes to IDLE at the next edge.
  - `bus_req`, `bus_we`, `bus_be`, `bus_addr`, `bus_wdata`, `m_rdata`, counter = 0.
  - `m_stall`, `m_exc`, `m_exccode` = 0 (given `m_req`=0).
  - An access in flight is abandoned; a late ack after reset is ignored.

## Timing
- **Aligned access, ack in first BUSY cycle:** 3 cycles, i.e. IDLE(accept), BUSY, DONE.
  - `m_stall` high for 2 cycles.
  - `bus_req` rises one edge after accept.
- **Each extra cycle without ack** adds 1 stall cycle.
- **Misaligned access:** 0 stall cycles; exception visible in the same cycle.
- **Back-to-back accesses:** minimum 3 cycles each, because DONE always passes through IDLE.
- **Combinational vs registered:**
  - `m_stall`, `m_exc`, `m_exccode` are combinational from state and M inputs.
  - All bus-side outputs are registered.

## Configuration
- **`DM_BUS_TIMEOUT_EN` defined:**
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches `TIMEOUT`: drop `bus_req`, go to DONE, assert `m_exc`=1 with `m_exccode`=7 in DONE; `m_rdata`=0.
  - An ack in the same cycle as expiry wins, and no error is raised.
- **Not defined:** no counter; BUSY waits for `bus_ack` indefinitely, and code 7 is never produced.

## Test plan
- sb at addr 0x0000_0013, `m_wdata`=0x1234_56AB, ack in first BUSY cycle → `bus_be`=1000, `bus_wdata`=0xABAB_ABAB, `bus_addr`=0x10. Stall 2 cycles; no exception.
- lh signed at 0x0000_0006, `bus_rdata`=0x8001_7FFF, ack delayed 3 cycles → `m_rdata`=0xFFFF_8001 in DONE. Stall 5 cycles; `bus_req` high for exactly 4 cycles.
- lw at 0x0000_0002 → same-cycle `m_exc`=1, code 4, `m_stall`=0, `bus_req` never asserted. sh at 0x0000_0001 → code 5.
- Reset asserted in the 2nd BUSY cycle of sw 0x0000_0100 → next cycle IDLE, `bus_req`=0, `m_stall`=0. An ack one cycle later is ignored.
- With `DM_BUS_TIMEOUT_EN` and `TIMEOUT`=4, load with no ack → `bus_req` high exactly 4 cycles, then DONE with `m_exc`=1, code 7, `m_rdata`=0.
- Without `DM_BUS_TIMEOUT_EN`, no ack for 300 cycles → still BUSY and stalled; ack at cycle 301 → DONE next cycle.
